// File: rtl/dbus_arbiter_if.sv
// ---------------------------------------------------------------------------
// dbus_arbiter_if
// Bundles the two master request/response channels and the shared slave
// channel of the data-bus arbiter.
//   slave  : arbiter side (serves the masters, drives the slave bus)
//   master : environment side (load-store unit, aux master, data slave)
// ---------------------------------------------------------------------------
interface dbus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // master 0 (core load-store unit)
   logic              m0_req;
   logic              m0_wr;
   logic              m0_lock;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic [3:0]        m0_mask;
   logic              m0_gnt;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;

   // master 1 (auxiliary: DMA / boot loader)
   logic              m1_req;
   logic              m1_wr;
   logic              m1_lock;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic [3:0]        m1_mask;
   logic              m1_gnt;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;

   // shared slave (data_cache / UART select path)
   logic              s_sel;
   logic              s_wr;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [3:0]        s_mask;
   logic [DATA_W-1:0] s_rdata;

   modport slave (
      input  m0_req, m0_wr, m0_lock, m0_addr, m0_wdata, m0_mask,
      output m0_gnt, m0_ack, m0_rdata,
      input  m1_req, m1_wr, m1_lock, m1_addr, m1_wdata, m1_mask,
      output m1_gnt, m1_ack, m1_rdata,
      output s_sel, s_wr, s_addr, s_wdata, s_mask,
      input  s_rdata
   );

   modport master (
      output m0_req, m0_wr, m0_lock, m0_addr, m0_wdata, m0_mask,
      input  m0_gnt, m0_ack, m0_rdata,
      output m1_req, m1_wr, m1_lock, m1_addr, m1_wdata, m1_mask,
      input  m1_gnt, m1_ack, m1_rdata,
      input  s_sel, s_wr, s_addr, s_wdata, s_mask,
      output s_rdata
   );
endinterface

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
// Two-master arbiter for the shared data bus. Registered grant FSM
// (IDLE / OWN0 / OWN1) with round-robin fairness, bursts bounded to
// MAX_BURST beats while the other master waits, direct owner-to-owner
// handover and pass-through read data.
//
// Optional build macro:
//   FIXED_PRIO_EN - master 0 always wins contention; the burst bound
//                   applies to master 1 only. Undefined: round-robin,
//                   burst bound on both masters.
// ---------------------------------------------------------------------------
module dbus_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           rst,
   dbus_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;      // beats taken by current owner
   logic              r_rr;       // 0: m0 favoured on next tie, 1: m1
   logic              r_m0_gnt;
   logic              r_m1_gnt;

   state_t            w_next_state;
   logic [CNT_W-1:0]  w_next_cnt;
   state_t            w_oth_state;
   logic              w_own_req;
   logic              w_own_wr;
   logic              w_own_lock;
   logic              w_oth_req;
   logic [ADDR_W-1:0] w_own_addr;
   logic [DATA_W-1:0] w_own_wdata;
   logic [3:0]        w_own_mask;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_limit;
   logic              w_pick_m1;
   logic              w_bounded;
   logic              w_may_yield;

   // Arbitration policy: tie-break in IDLE, burst bound, and whether an
   // unlocked owner gives the bus away to a waiting master.
`ifdef FIXED_PRIO_EN
   assign w_pick_m1   = 1'b0;
   assign w_bounded   = (r_state == ST_OWN1);
   assign w_may_yield = (r_state == ST_OWN1);
`else
   assign w_pick_m1   = r_rr;
   assign w_bounded   = 1'b1;
   assign w_may_yield = 1'b1;
`endif

   // Select the current owner's request side and the other master's request.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      w_own_req   = 1'b0;
      w_own_wr    = 1'b0;
      w_own_lock  = 1'b0;
      w_own_addr  = '0;
      w_own_wdata = '0;
      w_own_mask  = '0;
      w_oth_req   = 1'b0;
      w_oth_state = ST_IDLE;
      case (r_state)
         ST_OWN0: begin
            w_own_req   = bus.m0_req;
            w_own_wr    = bus.m0_wr;
            w_own_lock  = bus.m0_lock;
            w_own_addr  = bus.m0_addr;
            w_own_wdata = bus.m0_wdata;
            w_own_mask  = bus.m0_mask;
            w_oth_req   = bus.m1_req;
            w_oth_state = ST_OWN1;
         end
         ST_OWN1: begin
            w_own_req   = bus.m1_req;
            w_own_wr    = bus.m1_wr;
            w_own_lock  = bus.m1_lock;
            w_own_addr  = bus.m1_addr;
            w_own_wdata = bus.m1_wdata;
            w_own_mask  = bus.m1_mask;
            w_oth_req   = bus.m0_req;
            w_oth_state = ST_OWN0;
         end
         default: ;
      endcase
   end

   // Saturating beat count after this cycle's beat; limit reached when the
   // owner has used its full burst allowance.
   assign w_cnt_inc = (r_cnt == MAX_CNT) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_limit   = w_bounded && (w_cnt_inc == MAX_CNT);

   // End-of-cycle ownership decision and next beat count.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            w_next_cnt = '0;
            if (bus.m0_req && bus.m1_req)
               w_next_state = w_pick_m1 ? ST_OWN1 : ST_OWN0;
            else if (bus.m0_req)
               w_next_state = ST_OWN0;
            else if (bus.m1_req)
               w_next_state = ST_OWN1;
            else
               w_next_state = ST_IDLE;
         end
         ST_OWN0, ST_OWN1: begin
            if (!w_own_req) begin
               // no beat: hand over or release the bus
               w_next_state = w_oth_req ? w_oth_state : ST_IDLE;
               w_next_cnt   = '0;
            end else if (w_own_lock && !w_limit) begin
               // locked burst still inside its allowance
               w_next_cnt = w_cnt_inc;
            end else if (w_own_lock) begin
               // allowance used up: yield if anyone waits, else restart count
               if (w_oth_req)
                  w_next_state = w_oth_state;
               w_next_cnt = '0;
            end else if (w_oth_req && w_may_yield) begin
               // unlocked beat with a waiting master: direct handover
               w_next_state = w_oth_state;
               w_next_cnt   = '0;
            end else begin
               w_next_cnt = w_cnt_inc;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // Grant FSM: state, beat counter, round-robin pointer and registered grants.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_rr     <= 1'b0;
         r_m0_gnt <= 1'b0;
         r_m1_gnt <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_cnt    <= w_next_cnt;
         r_m0_gnt <= (w_next_state == ST_OWN0);
         r_m1_gnt <= (w_next_state == ST_OWN1);
         if (w_next_state == ST_OWN0)
            r_rr <= 1'b1;
         else if (w_next_state == ST_OWN1)
            r_rr <= 1'b0;
      end
   end

   // Slave bus follows the owner; everything is zero while idle or in reset.
   assign bus.s_sel   = w_own_req;
   assign bus.s_wr    = w_own_req & w_own_wr;
   assign bus.s_addr  = w_own_addr;
   assign bus.s_wdata = w_own_wdata;
   assign bus.s_mask  = w_own_mask;

   // Master responses: beat completes when the owner requests; read data
   // is passed through to the owner only.
   assign bus.m0_gnt   = r_m0_gnt;
   assign bus.m1_gnt   = r_m1_gnt;
   assign bus.m0_ack   = r_m0_gnt & bus.m0_req;
   assign bus.m1_ack   = r_m1_gnt & bus.m1_req;
   assign bus.m0_rdata = r_m0_gnt ? bus.s_rdata : '0;
   assign bus.m1_rdata = r_m1_gnt ? bus.s_rdata : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dbus_arbiter
// Directed stimulus with a behavioural ownership model checked every cycle,
// plus hand-computed expectations for the key scenarios.
// ---------------------------------------------------------------------------
module tb_dbus_arbiter;

   localparam int MAX = 4;
`ifdef FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave read data: fixed word at 0x100, inverted address elsewhere.
   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEAD_BEEF : ~a;
   endfunction
   assign bus.s_rdata = slave_data(bus.s_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- ownership model ----------------
   // own: -1 nobody, 0 or 1 owning master; beats: beats used in burst;
   // rr: master favoured on the next tie.
   typedef struct {
      int own;
      int beats;
      int rr;
   } model_t;

   model_t mdl;

   function automatic model_t model_next(input model_t cur, input bit r0, l0, r1, l1);
      model_t nx;
      bit     req[2];
      bit     lock[2];
      int     o, t, used;
      bit     bounded;
      nx = cur;
      req[0] = r0;  req[1] = r1;
      lock[0] = l0; lock[1] = l1;
      if (cur.own < 0) begin
         if (r0 && r1)  nx.own = (FIXED || cur.rr == 0) ? 0 : 1;
         else if (r0)   nx.own = 0;
         else if (r1)   nx.own = 1;
         else           nx.own = -1;
      end else begin
         o = cur.own;
         t = 1 - o;
         bounded = !FIXED || (o == 1);
         used = (cur.beats + 1 > MAX) ? MAX : cur.beats + 1;
         if (!req[o]) begin
            nx.own = req[t] ? t : -1;
         end else if (lock[o]) begin
            if (!bounded || used < MAX) nx.beats = used;
            else begin
               nx.own   = req[t] ? t : o;
               nx.beats = 0;
            end
         end else begin
            if (req[t] && !(FIXED && o == 0)) nx.own = t;
            else nx.beats = used;
         end
      end
      if (nx.own != cur.own || nx.own < 0) nx.beats = 0;
      if (nx.own >= 0) nx.rr = 1 - nx.own;
      return nx;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) mdl <= '{own: -1, beats: 0, rr: 0};
      else     mdl <= model_next(mdl, bus.m0_req, bus.m0_lock, bus.m1_req, bus.m1_lock);
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      logic        e_req, e_wr;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_mask;
      e_req = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_mask = '0;
      if (mdl.own == 0) begin
         e_req = bus.m0_req; e_wr = bus.m0_wr; e_addr = bus.m0_addr;
         e_wdata = bus.m0_wdata; e_mask = bus.m0_mask;
      end else if (mdl.own == 1) begin
         e_req = bus.m1_req; e_wr = bus.m1_wr; e_addr = bus.m1_addr;
         e_wdata = bus.m1_wdata; e_mask = bus.m1_mask;
      end
      check("m0_gnt",   bus.m0_gnt,   mdl.own == 0);
      check("m1_gnt",   bus.m1_gnt,   mdl.own == 1);
      check("m0_ack",   bus.m0_ack,   (mdl.own == 0) && bus.m0_req);
      check("m1_ack",   bus.m1_ack,   (mdl.own == 1) && bus.m1_req);
      check("s_sel",    bus.s_sel,    e_req);
      check("s_wr",     bus.s_wr,     e_req & e_wr);
      check("s_addr",   bus.s_addr,   e_addr);
      check("s_wdata",  bus.s_wdata,  e_wdata);
      check("s_mask",   bus.s_mask,   e_mask);
      check("m0_rdata", bus.m0_rdata, (mdl.own == 0) ? slave_data(e_addr) : 32'h0);
      check("m1_rdata", bus.m1_rdata, (mdl.own == 1) ? slave_data(e_addr) : 32'h0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_m0(input bit req, wr, lock, input logic [31:0] addr);
      bus.m0_req = req; bus.m0_wr = wr; bus.m0_lock = lock; bus.m0_addr = addr;
      bus.m0_wdata = 32'h1000_0000 | addr; bus.m0_mask = 4'hF;
   endtask

   task automatic drive_m1(input bit req, wr, lock, input logic [31:0] addr);
      bus.m1_req = req; bus.m1_wr = wr; bus.m1_lock = lock; bus.m1_addr = addr;
      bus.m1_wdata = 32'h2000_0000 | addr; bus.m1_mask = 4'h3;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_m0(0, 0, 0, 32'h0);
      drive_m1(0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int acks;
      rst = 1'b1;
      drive_m0(0, 0, 0, 32'h0);
      drive_m1(0, 0, 0, 32'h0);
      #1;
      check("rst_gnt0", bus.m0_gnt, 1'b0);
      check("rst_sel",  bus.s_sel,  1'b0);
      check("rst_addr", bus.s_addr, 32'h0);
      do_reset();

      // 1: single read by m0, granted one cycle after request
      drive_m0(1, 0, 0, 32'h100);
      @(negedge clk);
      check("t1_gnt_c1", bus.m0_gnt, 1'b0);
      next_cycle();
      @(negedge clk);
      check("t1_gnt_c2",  bus.m0_gnt,   1'b1);
      check("t1_ack_c2",  bus.m0_ack,   1'b1);
      check("t1_rdata",   bus.m0_rdata, 32'hDEAD_BEEF);
      check("t1_s_wr",    bus.s_wr,     1'b0);
      check("t1_m1_gnt",  bus.m1_gnt,   1'b0);
      next_cycle();
      drive_m0(0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("t1_idle", bus.m0_gnt, 1'b0);

      // 2: both request unlocked from reset: m0, m1, m0, m1, m0
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         drive_m0(1, 0, 0, 32'h300 + i * 4);
         drive_m1(1, 0, 0, 32'h380 + i * 4);
         @(negedge clk);
`ifndef FIXED_PRIO_EN
         if (i == 1) check("t2_idle", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
         else        check("t2_alt",  {bus.m1_gnt, bus.m0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
         next_cycle();
      end
      drive_m0(0, 0, 0, 32'h0);
      drive_m1(0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();

      // 3: m1 locked write burst with m0 waiting: exactly 4 beats, then m0
      do_reset();
      acks = 0;
      drive_m1(1, 1, 1, 32'h200);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive_m1(1, 1, 1, 32'h200 + k * 4);
         drive_m0(1, 0, 0, 32'h180);
         @(negedge clk);
         check("t3_gnt1", bus.m1_gnt, 1'b1);
         check("t3_s_wr", bus.s_wr,   1'b1);
         check("t3_addr", bus.s_addr, 32'h200 + k * 4);
         if (bus.m1_ack) acks++;
         next_cycle();
      end
      drive_m1(0, 0, 0, 32'h0);
      @(negedge clk);
      check("t3_handover", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
      check("t3_acks", acks, 4);
      next_cycle();
      drive_m0(0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();

      // 4: m1 locked burst alone keeps the bus beyond MAX beats
      do_reset();
      acks = 0;
      drive_m1(1, 0, 1, 32'h400);
      next_cycle();
      for (int k = 0; k < 8; k++) begin
         drive_m1(1, 0, 1, 32'h400 + k * 4);
         @(negedge clk);
         check("t4_gnt1", bus.m1_gnt, 1'b1);
         if (bus.m1_ack) acks++;
         next_cycle();
      end
      check("t4_acks", acks, 8);
      drive_m1(0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();

      // 5: reset in the middle of a write burst
      do_reset();
      drive_m1(1, 1, 1, 32'h500);
      next_cycle();
      @(negedge clk);
      check("t5_pre_wr", bus.s_wr, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
      check("t5_sel", {bus.s_sel, bus.s_wr},    2'b00);
      check("t5_ack", bus.m1_ack, 1'b0);
      check("t5_addr", bus.s_addr, 32'h0);
      next_cycle();
      drive_m0(1, 0, 0, 32'h600);
      drive_m1(1, 0, 0, 32'h700);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("t5_idle", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
      next_cycle();
      @(negedge clk);
      check("t5_first", {bus.m1_gnt, bus.m0_gnt}, 2'b01);
      next_cycle();
      drive_m0(0, 0, 0, 32'h0);
      drive_m1(0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();

`ifdef FIXED_PRIO_EN
      // 6: fixed priority, both request unlocked: m0 keeps the bus
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         drive_m0(1, 0, 0, 32'h800);
         drive_m1(1, 0, 0, 32'h900);
         @(negedge clk);
         check("t6_gnt1", bus.m1_gnt, 1'b0);
         if (i > 1) check("t6_gnt0", bus.m0_gnt, 1'b1);
         next_cycle();
      end
      drive_m0(0, 0, 0, 32'h0);
      next_cycle();
      @(negedge clk);
      check("t6_m1_after", bus.m1_gnt, 1'b1);
      next_cycle();
      drive_m1(0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
Two-master arbiter sharing the single data bus (data_cache / UART select path) between the core load-store unit (master 0) and an auxiliary bus master such as a DMA or boot loader (master 1). Registered grant FSM with round-robin fairness, bounded locked bursts and pass-through read data. It sits between the load-store unit dbus outputs and the data_cache/uart slave inputs.

Parameters:
ADDR_W, 32, address width of masters and slave
DATA_W, 32, data width
MAX_BURST, 4, max consecutive beats one master may hold while the other requests (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 (core) transfer request
m0_wr  input  1  master 0 write (1) / read (0)
m0_lock  input  1  master 0 wants to keep bus for following beat
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_mask  input  4  master 0 byte mask
m0_gnt  output  1  master 0 owns bus (registered)
m0_ack  output  1  master 0 beat completes this cycle
m0_rdata  output  DATA_W  read data to master 0
m1_req, m1_wr, m1_lock, m1_addr, m1_wdata, m1_mask  inputs  as master 0  master 1 request side
m1_gnt, m1_ack, m1_rdata  outputs  as master 0  master 1 response side
s_sel  output  1  slave select
s_wr  output  1  slave write strobe
s_addr  output  ADDR_W  slave address
s_wdata  output  DATA_W  slave write data
s_mask  output  4  slave byte mask
s_rdata  input  DATA_W  slave read data (combinational w.r.t. s_addr)

Behaviour:
- FSM states: IDLE, OWN0, OWN1. mX_gnt = (state==OWNX), registered.
- Reset (async, any time incl. mid-burst): state IDLE, beat counter 0, rr pointer favours m0; all gnt, ack, s_sel, s_wr low; s_addr/s_wdata/s_mask zero. Slave writes in flight are abandoned.
- IDLE: no grant, slave outputs zero. If any req: grant next cycle (1-cycle arbitration latency). Single requester wins; both -> rr pointer winner.
- Beat: mX_ack = mX_req & mX_gnt (combinational). During OWNX: s_sel = mX_req, s_wr = mX_req & mX_wr, s_addr/s_wdata/s_mask muxed from owner; mX_rdata = s_rdata for owner, non-owner rdata = 0. Non-owner ack always 0.
- Beat counter increments on each owner ack, saturating at MAX_BURST; cleared on ownership change or IDLE.
- End-of-cycle decision in OWNX:
  - owner req=0 (no beat): -> other master if it requests, else IDLE.
  - beat with lock=1 and counter+1 < MAX_BURST: stay.
  - beat with lock=1 and counter+1 == MAX_BURST: switch to other if it requests, else stay with counter cleared.
  - beat with lock=0: switch to other if it requests; else stay if owner still req, else IDLE.
- Ownership switches directly OWN0<->OWN1 with no idle bubble; rr pointer set to the non-winning master on every grant.
- Simultaneous requests arriving in IDLE with equal priority: rr decides; after reset m0 first.
- Requests sampled only on clk edges; changing owner signals without req has no slave effect.

Optional Feature:
FIXED_PRIO_EN: when defined, m0 always wins contention in IDLE and at every handover decision (rr pointer ignored; MAX_BURST limit still applies to m1 only, m0 bursts unbounded while lock=1). Undefined: round-robin and MAX_BURST on both masters as above.

Test Plan:
- Reset then m0_req=1 read addr 0x100, s_rdata=0xDEADBEEF -> m0_gnt high cycle 2, m0_ack same cycle, m0_rdata=0xDEADBEEF, s_wr=0.
- m0 and m1 both req from IDLE after reset -> OWN0 first; after one unlocked beat OWN1 next cycle, no bubble; then alternate m0,m1,m0.
- m1 locked write burst to 0x200..0x20C with m0 requesting, MAX_BURST=4 -> exactly 4 m1 acks, s_wr high each, then m0_gnt next cycle.
- m1 locked burst, m0 idle -> m1 holds beyond 4 beats (counter clears), m1_ack every cycle for 8 beats.
- Assert rst mid-burst while s_wr=1 -> same-cycle gnt/s_sel/s_wr=0, state IDLE; after release first contention grants m0.
- FIXED_PRIO_EN defined, both req continuously unlocked -> m0_gnt held every cycle, m1_gnt never high until m0_req drops.
